// File: rtl/div_sched_pkg.sv
// Shared types and constants for the complex-divider scheduler and the divider top.
package div_sched_pkg;

  typedef enum logic {
    OWN_EST = 1'b0,
    OWN_EQ  = 1'b1
  } owner_e;

  localparam int DIV_LATENCY_DEF = 36;

  // Bits needed to hold values 0..n inclusive.
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and moves only on a grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic last_q;

  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      if (&i_req) o_gnt = last_q ? 2'b01 : 2'b10;
      else        o_gnt = i_req;
    end
  end

  // Reset to 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  last_q <= 1'b1;
    else if (|o_gnt) last_q <= o_gnt[1];
  end

endmodule

// File: rtl/div_complex_sched.sv
// Shares one pipelined complex divider between the pilot estimator (req0) and the equalizer (req1),
// tracking owner/tag/zero-divisor alongside the divider and routing each quotient back in grant order.
module div_complex_sched
  import div_sched_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int TAG_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_req0_valid,
  output logic                 o_req0_ready,
  input  logic [DATA_SIZE-1:0] i_req0_a_i,
  input  logic [DATA_SIZE-1:0] i_req0_a_q,
  input  logic [DATA_SIZE-1:0] i_req0_b_i,
  input  logic [DATA_SIZE-1:0] i_req0_b_q,
  input  logic [TAG_W-1:0]     i_req0_tag,
  input  logic                 i_req1_valid,
  output logic                 o_req1_ready,
  input  logic [DATA_SIZE-1:0] i_req1_a_i,
  input  logic [DATA_SIZE-1:0] i_req1_a_q,
  input  logic [DATA_SIZE-1:0] i_req1_b_i,
  input  logic [DATA_SIZE-1:0] i_req1_b_q,
  input  logic [TAG_W-1:0]     i_req1_tag,
  output logic                 o_div_valid,
  output logic [DATA_SIZE-1:0] o_div_a_i,
  output logic [DATA_SIZE-1:0] o_div_a_q,
  output logic [DATA_SIZE-1:0] o_div_b_i,
  output logic [DATA_SIZE-1:0] o_div_b_q,
  input  logic [DATA_SIZE-1:0] i_div_q_i,
  input  logic [DATA_SIZE-1:0] i_div_q_q,
  output logic                 o_res0_valid,
  output logic                 o_res1_valid,
  output logic [DATA_SIZE-1:0] o_res_i,
  output logic [DATA_SIZE-1:0] o_res_q,
  output logic [TAG_W-1:0]     o_res_tag,
  output logic                 o_res_dz,
  output logic                 o_busy
);

  localparam int STAGES = DIV_LATENCY;
  localparam int CNT_W  = clog2_p1(DIV_LATENCY + 2);

  typedef struct packed {
    owner_e           own;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } slot_t;

  logic [1:0]           gnt;
  logic                 grant, sel, arb_en, res_stb;
  logic [DATA_SIZE-1:0] a_i, a_q, b_i, b_q;
  logic [TAG_W-1:0]     tag;
  logic [STAGES:0]      vld_pipe;
  slot_t                slot_pipe [STAGES:0];
  logic [CNT_W-1:0]     cnt;

  // Readies are combinational, so mask them with reset to keep all outputs low while it is held.
  assign arb_en = i_enable & i_reset_n;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_enable (arb_en),
    .i_req    ({i_req1_valid, i_req0_valid}),
    .o_gnt    (gnt)
  );

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];
  assign grant        = |gnt;
  assign sel          = gnt[1];

  assign a_i = sel ? i_req1_a_i : i_req0_a_i;
  assign a_q = sel ? i_req1_a_q : i_req0_a_q;
  assign b_i = sel ? i_req1_b_i : i_req0_b_i;
  assign b_q = sel ? i_req1_b_q : i_req0_b_q;
  assign tag = sel ? i_req1_tag : i_req0_tag;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_div_valid <= 1'b0;
      o_div_a_i   <= '0;
      o_div_a_q   <= '0;
      o_div_b_i   <= '0;
      o_div_b_q   <= '0;
    end else begin
      o_div_valid <= grant;
      if (grant) begin
        o_div_a_i <= a_i;
        o_div_a_q <= a_q;
        o_div_b_i <= b_i;
        o_div_b_q <= b_q;
      end
    end
  end

  // Slot k is valid k+1 cycles after the grant; the tail lines up with the quotient on i_div_q_*.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_pipe <= '0;
      for (int k = 0; k <= STAGES; k++) slot_pipe[k] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[STAGES-1:0], grant};
      slot_pipe[0] <= '{own: owner_e'(sel), tag: tag, dz: (b_i == '0) && (b_q == '0)};
      for (int k = 1; k <= STAGES; k++) slot_pipe[k] <= slot_pipe[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_res0_valid <= 1'b0;
      o_res1_valid <= 1'b0;
      o_res_i      <= '0;
      o_res_q      <= '0;
      o_res_tag    <= '0;
      o_res_dz     <= 1'b0;
    end else begin
      o_res0_valid <= vld_pipe[STAGES] && (slot_pipe[STAGES].own == OWN_EST);
      o_res1_valid <= vld_pipe[STAGES] && (slot_pipe[STAGES].own == OWN_EQ);
      if (vld_pipe[STAGES]) begin
        o_res_i   <= slot_pipe[STAGES].dz ? '0 : i_div_q_i;
        o_res_q   <= slot_pipe[STAGES].dz ? '0 : i_div_q_q;
        o_res_tag <= slot_pipe[STAGES].tag;
        o_res_dz  <= slot_pipe[STAGES].dz;
      end
    end
  end

  assign res_stb = o_res0_valid | o_res1_valid;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) cnt <= '0;
    else begin
      case ({grant, res_stb})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_busy = (cnt != '0) || o_div_valid;

endmodule

// File: tb/tb_div_complex_sched.sv
// Randomized bench: a cycle-level reference of the scheduler's arbitration and result timing,
// plus a behavioural complex divider with fixed latency.
module tb_div_complex_sched;

  localparam int L  = 36;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int M_IDLE = 0, M_BOTH = 1, M_REQ0 = 2, M_FAIR = 3, M_RAND = 4;

  logic clk = 1'b0;
  logic rst_n, en;
  logic [1:0] v;
  logic [DW-1:0] ai [2], aq [2], bi [2], bq [2];
  logic [TW-1:0] tg [2];

  logic o_req0_ready, o_req1_ready, o_div_valid, o_res0_valid, o_res1_valid, o_res_dz, o_busy;
  logic [DW-1:0] o_div_a_i, o_div_a_q, o_div_b_i, o_div_b_q, o_res_i, o_res_q;
  logic [DW-1:0] div_q_i, div_q_q;
  logic [TW-1:0] o_res_tag;

  always #5 clk = ~clk;

  div_complex_sched #(.DATA_SIZE(DW), .DIV_LATENCY(L), .TAG_W(TW)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en),
    .i_req0_valid(v[0]), .o_req0_ready(o_req0_ready),
    .i_req0_a_i(ai[0]), .i_req0_a_q(aq[0]), .i_req0_b_i(bi[0]), .i_req0_b_q(bq[0]),
    .i_req0_tag(tg[0]),
    .i_req1_valid(v[1]), .o_req1_ready(o_req1_ready),
    .i_req1_a_i(ai[1]), .i_req1_a_q(aq[1]), .i_req1_b_i(bi[1]), .i_req1_b_q(bq[1]),
    .i_req1_tag(tg[1]),
    .o_div_valid(o_div_valid),
    .o_div_a_i(o_div_a_i), .o_div_a_q(o_div_a_q), .o_div_b_i(o_div_b_i), .o_div_b_q(o_div_b_q),
    .i_div_q_i(div_q_i), .i_div_q_q(div_q_q),
    .o_res0_valid(o_res0_valid), .o_res1_valid(o_res1_valid),
    .o_res_i(o_res_i), .o_res_q(o_res_q), .o_res_tag(o_res_tag), .o_res_dz(o_res_dz),
    .o_busy(o_busy)
  );

  // Behavioural divider; a zero divisor yields a deliberately nonzero value.
  function automatic logic [31:0] cdiv(input logic [DW-1:0] xi, xq, yi, yq);
    longint ar, aim, br, bim, den, qr, qim;
    ar  = longint'($signed(xi));
    aim = longint'($signed(xq));
    br  = longint'($signed(yi));
    bim = longint'($signed(yq));
    den = br * br + bim * bim;
    if (den == 0) return 32'h7fff_8001;
    qr  = (ar * br + aim * bim) / den;
    qim = (aim * br - ar * bim) / den;
    return {qr[15:0], qim[15:0]};
  endfunction

  logic [31:0] dq [L];
  always @(posedge clk) begin
    dq[0] <= cdiv(o_div_a_i, o_div_a_q, o_div_b_i, o_div_b_q);
    for (int k = 1; k < L; k++) dq[k] <= dq[k-1];
  end
  assign div_q_i = dq[L-1][31:16];
  assign div_q_q = dq[L-1][15:0];

  typedef struct {
    int            own;
    logic [TW-1:0] tag;
    logic [DW-1:0] ri, rq;
    logic          dz;
    int            due;
  } exp_t;

  exp_t q [$];
  int ntest = 0, nfail = 0;
  int cyc = 0, last = 1, nreq = 0, ndrop = 0, nflush = 0;
  int ngrant = 0, ndut_grant = 0, ndut_strobe = 0, nstrobe = 0;
  int w0 = 0, maxw = 0;
  bit iss_prev = 0;
  logic [DW-1:0] pa_i, pa_q, pb_i, pb_q, last_ri = '0, last_rq = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int r);
    int tmp;
    v[r]  = 1'b1;
    ai[r] = 16'($urandom);
    aq[r] = 16'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      bi[r] = '0;
      bq[r] = '0;
    end else begin
      tmp = int'($urandom_range(0, 511)) - 256; bi[r] = tmp[15:0];
      tmp = int'($urandom_range(0, 511)) - 256; bq[r] = tmp[15:0];
    end
    tg[r] = 8'($urandom);
    nreq++;
  endtask

  // One clock of the reference: predicts the grant, the issue strobe, busy and any due result.
  task automatic step();
    int win, gw;
    exp_t e;
    logic [31:0] qv;
    #1;
    win = -1;
    if (en && rst_n) begin
      if (v[0] && v[1]) win = 1 - last;
      else if (v[0])    win = 0;
      else if (v[1])    win = 1;
    end
    chk("ready0", o_req0_ready, win == 0);
    chk("ready1", o_req1_ready, win == 1);
    chk("div_valid", o_div_valid, iss_prev);
    if (iss_prev) begin
      chk("div_a_i", o_div_a_i, pa_i);
      chk("div_a_q", o_div_a_q, pa_q);
      chk("div_b_i", o_div_b_i, pb_i);
      chk("div_b_q", o_div_b_q, pb_q);
    end
    chk("busy", o_busy, q.size() != 0);
    ndut_grant  += int'(o_req0_ready) + int'(o_req1_ready);
    ndut_strobe += int'(o_res0_valid) + int'(o_res1_valid);
    if (v[0] && en && !o_req0_ready) w0++; else w0 = 0;
    if (w0 > maxw) maxw = w0;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("res0_valid", o_res0_valid, e.own == 0);
      chk("res1_valid", o_res1_valid, e.own == 1);
      chk("res_i", o_res_i, e.ri);
      chk("res_q", o_res_q, e.rq);
      chk("res_tag", o_res_tag, e.tag);
      chk("res_dz", o_res_dz, e.dz);
      last_ri = e.ri;
      last_rq = e.rq;
      nstrobe++;
    end else begin
      chk("res0_idle", o_res0_valid, 0);
      chk("res1_idle", o_res1_valid, 0);
      chk("res_i_hold", o_res_i, last_ri);
      chk("res_q_hold", o_res_q, last_rq);
    end
    gw = win;
    if (win >= 0) begin
      qv     = cdiv(ai[win], aq[win], bi[win], bq[win]);
      e.own  = win;
      e.tag  = tg[win];
      e.dz   = (bi[win] == '0) && (bq[win] == '0);
      e.ri   = e.dz ? '0 : qv[31:16];
      e.rq   = e.dz ? '0 : qv[15:0];
      e.due  = cyc + L + 2;
      q.push_back(e);
      last = win;
      pa_i = ai[win]; pa_q = aq[win]; pb_i = bi[win]; pb_q = bq[win];
      ngrant++;
    end
    iss_prev = (win >= 0);
    cyc++;
    @(negedge clk);
    if (gw >= 0) v[gw] = 1'b0;
  endtask

  task automatic gen(input int mode);
    case (mode)
      M_BOTH: for (int r = 0; r < 2; r++) if (!v[r]) new_req(r);
      M_REQ0: if (!v[0]) new_req(0);
      M_FAIR: begin
        if (!v[1]) new_req(1);
        if (!v[0] && (cyc % 3 == 0)) new_req(0);
      end
      M_RAND: begin
        for (int r = 0; r < 2; r++) if (!v[r] && $urandom_range(0, 2) != 0) new_req(r);
        en = ($urandom_range(0, 9) != 0);
      end
      default: ;
    endcase
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      gen(mode);
      step();
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ready0"}, o_req0_ready, 0);
    chk({pfx, "_ready1"}, o_req1_ready, 0);
    chk({pfx, "_div_valid"}, o_div_valid, 0);
    chk({pfx, "_div_a_i"}, o_div_a_i, 0);
    chk({pfx, "_div_b_q"}, o_div_b_q, 0);
    chk({pfx, "_res0"}, o_res0_valid, 0);
    chk({pfx, "_res1"}, o_res1_valid, 0);
    chk({pfx, "_res_i"}, o_res_i, 0);
    chk({pfx, "_res_q"}, o_res_q, 0);
    chk({pfx, "_res_tag"}, o_res_tag, 0);
    chk({pfx, "_res_dz"}, o_res_dz, 0);
    chk({pfx, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int s0, g0;
    rst_n = 1'b0;
    en    = 1'b1;
    v     = 2'b11;
    for (int r = 0; r < 2; r++) begin
      ai[r] = '0; aq[r] = '0; bi[r] = '0; bq[r] = '0; tg[r] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("rst");
    v = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Contention straight out of reset: alternating grants, no issue gaps.
    run(6, M_BOTH);
    run(L + 8, M_IDLE);

    // Single uncontended request: 100/10 = 10.
    v[0] = 1'b1; ai[0] = 16'd100; aq[0] = '0; bi[0] = 16'd10; bq[0] = '0; tg[0] = 8'd5;
    nreq++;
    run(L + 4, M_IDLE);
    chk("single_res_i", last_ri, 16'd10);

    // Zero divisor on the equalizer side.
    v[1] = 1'b1; ai[1] = 16'h1234; aq[1] = 16'h0567; bi[1] = '0; bq[1] = '0; tg[1] = 8'h3C;
    nreq++;
    run(L + 4, M_IDLE);

    // Enable drain: four grants then hold-off; the waiting request goes after re-enable.
    s0 = nstrobe;
    g0 = ndut_grant;
    for (int i = 0; i < 50 && (ndut_grant - g0) < 4; i++) begin
      gen(M_REQ0);
      step();
    end
    chk("drain_grants", ndut_grant - g0, 4);
    en = 1'b0;
    run(L + 6, M_REQ0);
    chk("drain_strobes", nstrobe - s0, 4);
    chk("drain_busy", o_busy, 0);
    en = 1'b1;
    run(1, M_IDLE);
    chk("reenable_grant", ndut_grant - g0, 5);
    run(L + 4, M_IDLE);

    // Random traffic with enable toggling.
    run(300, M_RAND);
    en = 1'b1;
    run(L + 8, M_IDLE);

    // Asynchronous reset with work in flight.
    for (int i = 0; i < 20 && q.size() < 3; i++) begin
      gen(M_BOTH);
      step();
    end
    chk("inflight_before_rst", q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    nflush += q.size();
    q.delete();
    ndrop += int'(v[0]) + int'(v[1]);
    v = 2'b00;
    last = 1; iss_prev = 0; last_ri = '0; last_rq = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(L + 6, M_IDLE);
    new_req(0);
    new_req(1);
    run(1, M_IDLE);
    run(L + 6, M_IDLE);

    // Backlogged equalizer, estimator every third cycle.
    w0 = 0;
    maxw = 0;
    run(60, M_FAIR);
    chk("fair_maxwait", maxw <= 1, 1);
    run(L + 8, M_IDLE);

    chk("xfers_vs_requests", ndut_grant + ndrop, nreq);
    chk("strobes_vs_grants", ndut_strobe + nflush, ndut_grant);
    chk("final_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/div_complex_sched.md
Name: div_complex_sched

Overview:
- Round-robin scheduler that shares one fully pipelined complex divider (a/b, DATA_SIZE I/Q) between two requesters.
- Requester 0 is the pilot channel estimator (rx/pilot); requester 1 is the data equalizer (rx/H).
- Issues at most one division per cycle and carries a tag/owner/zero-flag shift pipeline matched to the divider latency.
- Routes each result back to its owner; the divider's own valid output is not used.

Parameters:
- DATA_SIZE, 16, I/Q component width of operands and results.
- DIV_LATENCY, 36, cycles from issue (o_div_valid) to result on i_div_q_i/i_div_q_q; must be >= 1.
- TAG_W, 8, width of the requester tag (subcarrier index).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  when low, no new grants; in-flight work drains.
- i_req0_valid  in  1  requester 0 operand valid.
- o_req0_ready  out  1  requester 0 accepted this cycle.
- i_req0_a_i, i_req0_a_q, i_req0_b_i, i_req0_b_q  in  DATA_SIZE each  requester 0 operands.
- i_req0_tag  in  TAG_W  requester 0 tag.
- i_req1_valid, o_req1_ready, i_req1_a_i/a_q/b_i/b_q, i_req1_tag  same as requester 0, for requester 1.
- o_div_valid  out  1  issue strobe to the divider.
- o_div_a_i, o_div_a_q, o_div_b_i, o_div_b_q  out  DATA_SIZE each  registered operands to the divider.
- i_div_q_i, i_div_q_q  in  DATA_SIZE  divider quotient.
- o_res0_valid, o_res1_valid  out  1  one-cycle result strobe per owner.
- o_res_i, o_res_q  out  DATA_SIZE  result, shared by both owners.
- o_res_tag  out  TAG_W  tag of the result.
- o_res_dz  out  1  divide-by-zero flag for the result.
- o_busy  out  1  high while any request is in flight.

Behaviour:
- Reset: all outputs 0; last-grant pointer = 1, so requester 0 wins first; tag pipeline cleared; in-flight counter = 0.
- Handshake:
  - ready is combinational from valid, i_enable and arbiter state.
  - A transfer occurs when valid && ready.
  - At most one ready per cycle.
  - A requester must hold valid and data stable until ready.
- Arbitration:
  - One requester valid → it is granted.
  - Both valid → grant the one not granted last; the pointer updates only on a grant.
  - i_enable=0 → both ready low; valid requests wait and are not dropped.
- Issue stage (1 register):
  - On a grant, capture the operands into o_div_* and pulse o_div_valid the next cycle.
  - Push owner, tag and dz into pipeline slot 0, where dz = (b_i==0 && b_q==0).
  - Zero-divisor requests are still issued, to preserve ordering.
- Pipeline: DIV_LATENCY-deep shift of {valid, owner, tag, dz}, shifted every cycle with no stall.
- Result stage:
  - When the pipeline tail is valid, register the result and pulse o_res0_valid or o_res1_valid (selected by owner) for one cycle.
  - o_res_i/o_res_q = dz ? 0 : i_div_q_*, with o_res_dz = dz.
  - When no result is valid, o_res_* hold their last value.
- Total latency: grant cycle → result strobe = DIV_LATENCY + 2 cycles.
- o_busy:
  - An in-flight counter increments on a grant and decrements on a result strobe; both in one cycle → unchanged.
  - o_busy = (count != 0) || o_div_valid.
  - Counter width is $clog2(DIV_LATENCY+3).
- Throughput is 1 result/cycle sustained. Results return strictly in grant order; tags are never reordered.
- i_enable deasserted mid-stream: in-flight results still emerge on schedule; o_busy falls after the last one.
- i_reset_n asserted mid-operation: the pipeline and counter clear immediately and no stale strobes are produced after release. Requesters must re-issue.

Decomposition:
- Shared package div_sched_pkg:
  - owner encoding: OWN_EST=0, OWN_EQ=1.
  - default DIV_LATENCY constant, shared with the divider top.
  - helper function clog2_p1 for the counter width.
- Sub-module rr_arb2: 2-way round-robin arbiter with grant, pointer and enable. The tag/valid shift pipeline stays inline.

Test Plan:
- Single request, no contention: req0 a=(100,0), b=(10,0), tag=5, with the divider model returning (10,0) → o_res0_valid exactly DIV_LATENCY+2 cycles after the grant, o_res_i=10, o_res_tag=5, o_res_dz=0.
- Contention: both valid for 6 cycles from reset → grants alternate 0,1,0,1,0,1; results return in the same order with matching tags; no idle cycles on o_div_valid.
- Divide-by-zero: req1 b=(0,0), tag=0x3C → divider issued; o_res1_valid with o_res_i=o_res_q=0, o_res_dz=1, tag 0x3C.
- Enable drain: stream on req0, drop i_enable after 4 grants → no further ready; exactly 4 result strobes; o_busy low one cycle after the 4th strobe; waiting request granted after re-enable.
- Async reset mid-stream: assert i_reset_n low with 3 in flight → all outputs 0 immediately; zero result strobes after release; first post-reset grant goes to req0.
- Backlogged fairness: req1 continuously valid, req0 valid every 3rd cycle → req0 is never waiting more than 1 cycle; total grants equal valid transfers and no transfer is lost.
